// File: rtl/mem_access.sv
// mem_access: MEM stage of the RV32I pipeline.
//   Decodes loads/stores from the EXE/MEM registers, drives the data-memory
//   req/ack bus, extracts and extends load data, and fills the MEM/WB registers.
//   A bus access that is not acknowledged in its first cycle holds stall_mem high
//   until ack or timeout, and MEM/WB receives a bubble on every stalled cycle.
//   XLEN is 32 in practice: the byte lanes and dmem_be assume a 4-byte word.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pc/alu/rs2/instr/rd_mem   EXE/MEM register inputs
//   forward_mem               alu_mem passed straight through to EXE forwarding
//   stall_mem                 freeze IF..EXE and the EXE/MEM registers
//   dmem_*                    data-memory bus (req/we/addr/be/wdata out, rdata/ack in)
//   pc/result/instr/rd_wb     MEM/WB registers
//   mem_fault                 one-cycle pulse on misaligned/illegal access or timeout
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; a legal mem op requests the bus here
// WAIT  | request outstanding, upstream frozen, counting toward TIMEOUT
module mem_access #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_mem,
   input  logic [XLEN-1:0] alu_mem,
   input  logic [XLEN-1:0] rs2_mem,
   input  logic [XLEN-1:0] instr_mem,
   input  logic [4:0]      rd_addr_mem,
   output logic [XLEN-1:0] forward_mem,
   output logic            stall_mem,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic [XLEN-1:0] pc_wb,
   output logic [XLEN-1:0] result_wb,
   output logic [XLEN-1:0] instr_wb,
   output logic [4:0]      rd_addr_wb,
   output logic            mem_fault
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam int unsigned     CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT);
   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

   logic [0:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] pc_wb_q, pc_wb_d;
   logic [XLEN-1:0] result_wb_q, result_wb_d;
   logic [XLEN-1:0] instr_wb_q, instr_wb_d;
   logic [4:0]      rd_addr_wb_q, rd_addr_wb_d;
   logic            mem_fault_q, mem_fault_d;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [1:0]      off;
   logic            is_load, is_store, is_mem, f3_ok, align_ok, legal_op, dec_fault;
   logic [3:0]      be_lane;
   logic [XLEN-1:0] wdata_lane;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_val;
   logic            req, stall, done, timeout;

   // ---------------- decode ----------------
   always_comb begin
      opcode   = instr_mem[6:0];
      funct3   = instr_mem[14:12];
      off      = alu_mem[1:0];
      is_load  = (opcode == 7'b0000011);
      is_store = (opcode == 7'b0100011);
      is_mem   = is_load | is_store;
      f3_ok    = 1'b0;
      if (is_load) begin
         f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end else if (is_store) begin
         f3_ok = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
      end
      // funct3[1:0] encodes the access size for both loads and stores
      case (funct3[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = ~off[0];
         default: align_ok = (off == 2'b00);
      endcase
      legal_op  = is_mem & f3_ok & align_ok;
      dec_fault = is_mem & ~legal_op;
   end

   // ---------------- store lanes / load extract ----------------
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be_lane    = 4'b0001 << off;
            wdata_lane = {(XLEN/8){rs2_mem[7:0]}};
         end
         2'b01: begin
            be_lane    = 4'b0011 << off;
            wdata_lane = {(XLEN/16){rs2_mem[15:0]}};
         end
         default: begin
            be_lane    = 4'b1111;
            wdata_lane = rs2_mem;
         end
      endcase

      case (off)
         2'b00:   byte_sel = dmem_rdata[7:0];
         2'b01:   byte_sel = dmem_rdata[15:8];
         2'b10:   byte_sel = dmem_rdata[23:16];
         default: byte_sel = dmem_rdata[31:24];
      endcase
      half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

      case (funct3)
         3'b000:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sel};
         default: load_val = dmem_rdata;
      endcase
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req     = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (legal_op) begin
               req = 1'b1;
               if (dmem_ack) begin
                  done = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = ST_WAIT;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_WAIT: begin
            // Timeout wins over a late ack: the request is already withdrawn.
            if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
               timeout = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               req = 1'b1;
               if (dmem_ack) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  stall = 1'b1;
                  if (TIMEOUT != 0) begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- MEM/WB next value ----------------
   always_comb begin
      pc_wb_d      = pc_mem;
      result_wb_d  = '0;
      instr_wb_d   = NOP_INSTR;
      rd_addr_wb_d = '0;
      mem_fault_d  = 1'b0;
      if (timeout) begin
         mem_fault_d = 1'b1;
      end else if (stall) begin
         // bubble: the instruction writes back once, on completion
      end else if (done) begin
         result_wb_d  = is_load ? load_val : alu_mem;
         instr_wb_d   = instr_mem;
         rd_addr_wb_d = is_store ? 5'd0 : rd_addr_mem;
      end else if ((state_q == ST_IDLE) && dec_fault) begin
         mem_fault_d = 1'b1;
      end else if (!is_mem) begin
         result_wb_d  = alu_mem;
         instr_wb_d   = instr_mem;
         rd_addr_wb_d = rd_addr_mem;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pc_wb_q      <= '0;
         result_wb_q  <= '0;
         instr_wb_q   <= '0;
         rd_addr_wb_q <= '0;
         mem_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pc_wb_q      <= pc_wb_d;
         result_wb_q  <= result_wb_d;
         instr_wb_q   <= instr_wb_d;
         rd_addr_wb_q <= rd_addr_wb_d;
         mem_fault_q  <= mem_fault_d;
      end
   end

   // req/stall are combinational from state and inputs; gating with rst
   // makes them drop the instant reset is asserted.
   assign dmem_req    = req & ~rst;
   assign stall_mem   = stall & ~rst;
   assign dmem_we     = dmem_req & is_store;
   assign dmem_addr   = {alu_mem[XLEN-1:2], 2'b00};
   assign dmem_be     = be_lane;
   assign dmem_wdata  = wdata_lane;
   assign forward_mem = alu_mem;

   assign pc_wb       = pc_wb_q;
   assign result_wb   = result_wb_q;
   assign instr_wb    = instr_wb_q;
   assign rd_addr_wb  = rd_addr_wb_q;
   assign mem_fault   = mem_fault_q;

endmodule
